// File: rtl/adsr_envelope_if.sv
// Signal bundle between a note/oscillator source and the ADSR envelope stage.
// No valid/ready handshake: gate is level-sensitive and all controls are sampled live.
interface adsr_envelope_if #(
  parameter int ENV_W    = 16,
  parameter int SAMPLE_W = 8
);
  logic                gate;
  logic                wave_in;
  logic [ENV_W-1:0]    attack_step;
  logic [ENV_W-1:0]    decay_step;
  logic [ENV_W-1:0]    sustain_level;
  logic [ENV_W-1:0]    release_step;
  logic [SAMPLE_W-1:0] sample;
  logic [ENV_W-1:0]    level;
  logic [2:0]          stage;
  logic                active;

  modport master (
    output gate, wave_in, attack_step, decay_step, sustain_level, release_step,
    input  sample, level, stage, active
  );

  modport slave (
    input  gate, wave_in, attack_step, decay_step, sustain_level, release_step,
    output sample, level, stage, active
  );
endinterface

// File: rtl/adsr_envelope.sv
// ADSR amplitude envelope: prescaled-tick state machine scaling a 1-bit square wave
// into an unsigned sample. Stage is exported for observation.
module adsr_envelope #(
  parameter int TICK_DIV = 256,
  parameter int ENV_W    = 16,
  parameter int SAMPLE_W = 8
) (
  input  logic          clk,
  input  logic          reset,
  adsr_envelope_if.slave env
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } stage_t;

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TICK_DIV - 1);
  localparam logic [ENV_W-1:0] LEVEL_MAX = {ENV_W{1'b1}};

  logic [CNT_W-1:0]    cnt;
  logic                tick;
  logic                gate_d;
  logic                rise;
  logic                fall;
  stage_t              state, state_n;
  logic [ENV_W-1:0]    level_q, level_n;
  logic [SAMPLE_W-1:0] sample_q;
  logic                active_q;
  logic [ENV_W:0]      attack_sum;
  logic [ENV_W-1:0]    decay_diff;
  logic [ENV_W-1:0]    release_diff;

  assign tick = (cnt == CNT_LAST);
  assign rise = env.gate & ~gate_d;
  assign fall = ~env.gate & gate_d;

  // Attack sum is one bit wider so overflow is caught before it can wrap.
  assign attack_sum   = {1'b0, level_q} + {1'b0, env.attack_step};
  assign decay_diff   = level_q - env.decay_step;
  assign release_diff = level_q - env.release_step;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      gate_d   <= 1'b0;
      state    <= IDLE;
      level_q  <= '0;
      sample_q <= '0;
      active_q <= 1'b0;
    end else begin
      cnt      <= tick ? '0 : cnt + 1'b1;
      gate_d   <= env.gate;
      state    <= state_n;
      level_q  <= level_n;
      sample_q <= env.wave_in ? level_q[ENV_W-1 -: SAMPLE_W] : '0;
      active_q <= (state_n != IDLE);
    end
  end

  // Gate edges win over tick; on an edge cycle the level is held.
  always_comb begin
    state_n = state;
    level_n = level_q;
    if (rise) begin
      state_n = ATTACK;
    end else if (fall && (state == ATTACK || state == DECAY || state == SUSTAIN)) begin
      state_n = RELEASE;
    end else if (tick) begin
      case (state)
        IDLE: level_n = '0;
        ATTACK: begin
          if (env.attack_step == '0 || attack_sum >= {1'b0, LEVEL_MAX}) begin
            level_n = LEVEL_MAX;
            state_n = DECAY;
          end else begin
            level_n = attack_sum[ENV_W-1:0];
          end
        end
        DECAY: begin
          if (env.decay_step == '0 || level_q < env.decay_step ||
              decay_diff <= env.sustain_level) begin
            level_n = env.sustain_level;
            state_n = SUSTAIN;
          end else begin
            level_n = decay_diff;
          end
        end
        SUSTAIN: level_n = env.sustain_level;
        RELEASE: begin
          if (env.release_step == '0 || level_q <= env.release_step) begin
            level_n = '0;
            state_n = IDLE;
          end else begin
            level_n = release_diff;
          end
        end
        default: begin
          level_n = '0;
          state_n = IDLE;
        end
      endcase
    end
  end

  assign env.level  = level_q;
  assign env.sample = sample_q;
  assign env.stage  = state;
  assign env.active = active_q;

endmodule

// File: doc/adsr_envelope.md
# adsr_envelope

Amplitude envelope stage placed directly downstream of the square wave generator. It consumes the generator's 1-bit `value` output and a note gate, runs an attack/decay/sustain/release state machine on a prescaled tick, and emits an unsigned amplitude-scaled sample. Downstream mixing and DAC stages consume that sample.

## Interface
- `TICK_DIV`, default 256: number of clocks per envelope update tick; must be ≥1.
- `ENV_W`, default 16: envelope level width.
- `SAMPLE_W`, default 8: output sample width, ≤ `ENV_W`.

Ports:
- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `gate`  in  1  note held (1) or released (0).
- `wave_in`  in  1  square wave from the generator's `value` output.
- `attack_step`  in  ENV_W  level increment per tick in ATTACK; 0 means instant.
- `decay_step`  in  ENV_W  level decrement per tick in DECAY; 0 means instant.
- `sustain_level`  in  ENV_W  level held in SUSTAIN.
- `release_step`  in  ENV_W  level decrement per tick in RELEASE; 0 means instant.
- `sample`  out  SAMPLE_W  gated amplitude, registered.
- `level`  out  ENV_W  current envelope level, registered.
- `stage`  out  3  current state: IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.
- `active`  out  1  high whenever `stage` ≠ IDLE.

## Operation
- **Reset values:** `level`=0, `stage`=IDLE, `sample`=0, `active`=0, prescaler=0, registered gate copy `gate_d`=0.
- **Prescaler:** free-running counter over 0..TICK_DIV-1. `tick` is high in the cycle where count = TICK_DIV-1, then the count wraps to 0. With TICK_DIV=1, `tick` is high every cycle.
- **Gate edges:**
  - rise = `gate & ~gate_d`; fall = `~gate & gate_d`. `gate_d` updates every clock.
  - A rise in any state goes to ATTACK and keeps the current `level` (retrigger without a click).
  - A fall in ATTACK, DECAY or SUSTAIN goes to RELEASE and keeps `level`.
  - A fall in IDLE or RELEASE is ignored.
- **Priority:** an edge takes precedence over `tick` in the same cycle. In that cycle the state changes and `level` does not change.
- **Per-tick behaviour (no edge present):**
  - IDLE: `level` stays 0.
  - ATTACK: if `attack_step`=0, or `level`+`attack_step` ≥ 2^ENV_W−1 (sum computed ENV_W+1 wide), then `level` = 2^ENV_W−1 and go to DECAY. Otherwise add the step.
  - DECAY: if `decay_step`=0, or `level` < `decay_step`, or `level`−`decay_step` ≤ `sustain_level`, then `level`=`sustain_level` and go to SUSTAIN. Otherwise subtract the step.
  - SUSTAIN: `level` = `sustain_level` on every tick, so it tracks live changes.
  - RELEASE: if `release_step`=0 or `level` ≤ `release_step`, then `level`=0 and go to IDLE. Otherwise subtract the step.
- **Arithmetic:** no wrap-around in either direction; `level` saturates at 0 and at 2^ENV_W−1.
- **Sample path:** `sample` ← `wave_in` ? `level[ENV_W-1 -: SAMPLE_W]` : 0, registered every clock, independent of `tick`.

## Timing
- Gate rise sampled at edge N → `stage`=ATTACK visible after edge N. The first level change occurs at the first tick at or after edge N+1.
- `sample` lags `wave_in` and `level` by exactly one clock.
- `active` and `stage` are registered and update on the same edge as each other.
- Asserting `reset` mid-operation forces all outputs to their reset values immediately, without waiting for a clock. Releasing `reset` resumes from IDLE with the prescaler at 0. If `gate` is high at that point, it registers as a rise on the first clock.
- Input steps and `sustain_level` are sampled on the tick that uses them; no other latching.

## Test plan
Common settings: TICK_DIV=4, ENV_W=16, SAMPLE_W=8.
- **Attack:** `attack_step`=0x4000, gate raised from IDLE → `level` on successive ticks reads 0x4000, 0x8000, 0xC000, 0xFFFF. `stage` goes to DECAY on the tick that reaches 0xFFFF.
- **Decay:** `decay_step`=0x2000, `sustain_level`=0x8000, starting from 0xFFFF → `level` reads 0xDFFF, 0xBFFF, 0x9FFF, then 0x8000. `stage`=SUSTAIN from that tick. Changing `sustain_level` to 0x6000 gives `level`=0x6000 at the next tick.
- **Release:** gate dropped in SUSTAIN at 0x8000, `release_step`=0x3000 → `level` reads 0x5000, 0x2000, then 0. `stage` goes to IDLE and `active` goes to 0 on that tick.
- **Retrigger:** gate re-raised in RELEASE at `level`=0x5000, in the same cycle as a tick → `stage`=ATTACK and `level` stays 0x5000 that cycle. The next tick gives 0x9000 with `attack_step`=0x4000.
- **Sample gating:** hold `level`=0x8000 and toggle `wave_in` every 3 clocks → `sample` alternates 0x80 and 0x00, each change one clock after `wave_in` changes.
- **Reset mid-attack:** assert `reset` asynchronously with `level`=0x8000 → `level`, `sample`, `active` and `stage` read 0 before the next clock edge. After deassertion with gate held high, ATTACK restarts from 0.
